// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, bit timing and record geometry.
package uart_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned RECORD_W         = 48;
    localparam int unsigned BYTES_PER_RECORD = RECORD_W / BYTE_W;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    // System clocks per serial bit, truncated; must come out at 4 or more.
    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/serial2mem_if.sv
// Ringbuffer write port: assembled record, write strobe and full back-pressure.
interface serial2mem_if;
    import uart_pkg::*;

    logic [RECORD_W-1:0] write_data;
    logic                write_clock_enable;
    logic                write_full;

    modport master (
        output write_data,
        output write_clock_enable,
        input  write_full
    );

    modport slave (
        input  write_data,
        input  write_clock_enable,
        output write_full
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: rx synchronizer, start/data/stop sampling, byte and frame-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              frame_error_o,
    output logic              idle_o,
    output logic              start_o
);
    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    // Counter reaches zero on the sample cycle, hence the minus one on both loads.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]        fill_q;
    logic              armed_q;
    logic              fall_edge;

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_error_q, frame_error_d;

    // Synchronize rx; arm edge detection only once the line has really been seen high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            fill_q    <= '0;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            fill_q    <= {fill_q[0], 1'b1};
            if (fill_q[1] && rx_sync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign fall_edge = armed_q && rx_prev_q && !rx_sync_q;

    // Receiver state register and sampled data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state: half-bit start check, full-bit data/stop sampling.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall_edge) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DATA;
                    cnt_d   = BIT_LOAD;
                    bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_sync_q, shift_q[BYTE_W-1:1]};
                    cnt_d   = BIT_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_sync_q) begin
                    byte_valid_d = 1'b1;
                    state_d      = RX_IDLE;
                end else begin
                    frame_error_d = 1'b1;
                    state_d       = RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o        = shift_q;
    assign byte_valid_o  = byte_valid_q;
    assign frame_error_o = frame_error_q;
    assign idle_o        = (state_q == RX_IDLE);
    assign start_o       = (state_q == RX_IDLE) && fall_edge;

endmodule

// File: rtl/serial2mem.sv
// Serial-to-ringbuffer bridge: packs six received bytes into one 48-bit write.
module serial2mem
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ   = 12000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx,
    serial2mem_if.master  wr,
    output logic          frame_error,
    output logic          overrun,
    output logic          timeout
);
    localparam int unsigned  CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned  TCW          = $clog2(CLKS_PER_BIT);
    localparam int unsigned  BCW          = $clog2(TIMEOUT_BITS + 1);
    localparam logic [TCW-1:0] TICK_LAST  = TCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BITS_LAST  = BCW'(TIMEOUT_BITS - 1);
    localparam logic [2:0]   LAST_BYTE    = 3'(BYTES_PER_RECORD - 1);

    logic [BYTE_W-1:0]   rx_byte;
    logic                rx_byte_valid, rx_frame_error, rx_idle, rx_start;

    logic [2:0]          count_q, count_d;
    logic [RECORD_W-1:0] data_q, data_d;
    logic [TCW-1:0]      tick_q, tick_d;
    logic [BCW-1:0]      bits_q, bits_d;
    logic                timeout_q, timeout_d;
    logic                word_done;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock         (clock),
        .reset         (reset),
        .rx_i          (rx),
        .byte_o        (rx_byte),
        .byte_valid_o  (rx_byte_valid),
        .frame_error_o (rx_frame_error),
        .idle_o        (rx_idle),
        .start_o       (rx_start)
    );

    assign word_done = rx_byte_valid && (count_q == LAST_BYTE);

    // Assembler, byte counter and inter-byte timeout registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            data_q    <= '0;
            tick_q    <= '0;
            bits_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            data_q    <= data_d;
            tick_q    <= tick_d;
            bits_q    <= bits_d;
            timeout_q <= timeout_d;
        end
    end

    // Shift accepted bytes in; run the bit-time timer only while idle with a partial word.
    always_comb begin
        count_d   = count_q;
        data_d    = data_q;
        tick_d    = tick_q;
        bits_d    = bits_q;
        timeout_d = 1'b0;
        if (rx_byte_valid) begin
            data_d = {data_q[RECORD_W-BYTE_W-1:0], rx_byte};
            if (count_q == LAST_BYTE) begin
                count_d = '0;
            end else begin
                count_d = count_q + 3'd1;
            end
        end else if (rx_frame_error) begin
            count_d = '0;
        end
        if (rx_start || !rx_idle || (count_q == '0)) begin
            tick_d = '0;
            bits_d = '0;
        end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (bits_q == BITS_LAST) begin
                bits_d    = '0;
                count_d   = '0;
                timeout_d = 1'b1;
            end else begin
                bits_d = bits_q + 1'b1;
            end
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    // The strobe cycle already shows the completed word, so write_full is judged in that cycle.
    assign wr.write_data         = data_d;
    assign wr.write_clock_enable = word_done && !wr.write_full;
    assign overrun               = word_done && wr.write_full;
    assign frame_error           = rx_frame_error;
    assign timeout               = timeout_q;

endmodule
